// File: rtl/ycc_rgb_pkg.sv
// Shared constants, coefficient tables and stage payload type for the YCbCr->RGB pipeline.
// Coefficients are stored at 7 fractional bits and rescaled for other precisions.
package ycc_rgb_pkg;

  localparam int COEF_FRAC_REF = 7;
  localparam int COEF_W        = COEF_FRAC_REF + 5;

  // Column order of each coefficient row.
  localparam int KY   = 0;
  localparam int KCRR = 1;
  localparam int KCRG = 2;
  localparam int KCBG = 3;
  localparam int KCBB = 4;

  // Row index is {studio, matrix_sel}: full 601, full 709, studio 601, studio 709.
  localparam int COEF_TAB [4][5] = '{
    '{128, 179,  -91, -44, 227},
    '{128, 202,  -60, -24, 238},
    '{149, 204, -104, -50, 258},
    '{149, 229,  -68, -27, 270}
  };

  typedef struct packed {
    logic matrix_sel;
    logic studio;
  } side_t;

  function automatic int coef_w(input int frac);
    return frac + 5;
  endfunction

  // Rescale a reference coefficient to 'frac' fractional bits, rounding to nearest.
  function automatic int coef_scale(input int c, input int frac);
    if (frac >= COEF_FRAC_REF) begin
      return c <<< (frac - COEF_FRAC_REF);
    end
    return (c + (1 <<< (COEF_FRAC_REF - frac - 1))) >>> (COEF_FRAC_REF - frac);
  endfunction

  function automatic int ref_coef(input logic [1:0] set_idx, input int k);
    return COEF_TAB[set_idx][k];
  endfunction

endpackage

// File: rtl/ycc_rgb_clamp.sv
// Saturates a signed component sum to the unsigned range [0, 2^DATA_W-1] and flags clamping.
module ycc_rgb_clamp #(
  parameter int IN_W   = 24,
  parameter int DATA_W = 8
) (
  input  logic signed [IN_W-1:0]   sum,
  output logic        [DATA_W-1:0] sat,
  output logic                     clipped
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((1 << DATA_W) - 1);

  always_comb begin
    sat     = sum[DATA_W-1:0];
    clipped = 1'b0;
    if (sum[IN_W-1]) begin
      sat     = '0;
      clipped = 1'b1;
    end else if (sum > MAX_V) begin
      sat     = '1;
      clipped = 1'b1;
    end
  end

endmodule

// File: rtl/ycbcr_to_rgb_pipe.sv
// Four-stage YCbCr->RGB converter (offset, multiply, sum/round, saturate) with a global stall.
// Define YCC_RGB_STUDIO_RANGE_EN to add the per-pixel 'studio' (limited-range) input.
module ycbcr_to_rgb_pipe
  import ycc_rgb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int COEF_FRAC = 7,
  parameter int USER_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] cb,
  input  logic [DATA_W-1:0] cr,
  input  logic [USER_W-1:0] in_user,
  input  logic              in_valid,
  output logic              in_ready,
`ifdef YCC_RGB_STUDIO_RANGE_EN
  input  logic              studio,
`endif
  input  logic              matrix_sel,
  output logic [DATA_W-1:0] red,
  output logic [DATA_W-1:0] green,
  output logic [DATA_W-1:0] blue,
  output logic [USER_W-1:0] out_user,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clr_stats,
  output logic [15:0]       clip_count
);

  localparam int CW   = coef_w(COEF_FRAC);
  localparam int YO_W = DATA_W + 2;   // Y after optional studio offset, signed
  localparam int C_W  = DATA_W + 1;   // chroma after removing mid-scale, signed
  localparam int PW   = YO_W + CW;
  localparam int SW   = PW + 2;       // three-term sum plus rounding constant

  localparam logic signed [YO_W-1:0] STUDIO_Y_OFF = YO_W'(16 << (DATA_W - 8));
  localparam logic signed [C_W-1:0]  C_HALF       = C_W'(1 << (DATA_W - 1));
  localparam logic signed [SW-1:0]   ROUND_C      = SW'(1 << (COEF_FRAC - 1));

  logic studio_in;
`ifdef YCC_RGB_STUDIO_RANGE_EN
  assign studio_in = studio;
`else
  assign studio_in = 1'b0;
`endif

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage registers
  logic                    s1_valid_q, s2_valid_q, s3_valid_q;
  logic signed [YO_W-1:0]  s1_y_q;
  logic signed [C_W-1:0]   s1_cb_q, s1_cr_q;
  side_t                   s1_side_q;
  logic [USER_W-1:0]       s1_user_q, s2_user_q, s3_user_q;
  logic signed [PW-1:0]    s2_py_q, s2_pcrr_q, s2_pcrg_q, s2_pcbg_q, s2_pcbb_q;
  logic signed [SW-1:0]    s3_r_q, s3_g_q, s3_b_q;
  logic                    out_clip_q;

  // S1 combinational: input offsets
  logic signed [YO_W-1:0] y_off;
  logic signed [C_W-1:0]  cb_off, cr_off;
  side_t                  in_side;

  always_comb begin
    y_off = $signed({2'b00, y});
    if (studio_in) begin
      y_off = y_off - STUDIO_Y_OFF;
    end
    cb_off             = $signed({1'b0, cb}) - C_HALF;
    cr_off             = $signed({1'b0, cr}) - C_HALF;
    in_side.matrix_sel = matrix_sel;
    in_side.studio     = studio_in;
  end

  // S2 combinational: coefficient set chosen by the pixel's own side flags
  logic [1:0]           set_idx;
  logic signed [CW-1:0] k_y, k_crr, k_crg, k_cbg, k_cbb;

  always_comb begin
    set_idx = {s1_side_q.studio, s1_side_q.matrix_sel};
    k_y     = CW'(coef_scale(ref_coef(set_idx, KY),   COEF_FRAC));
    k_crr   = CW'(coef_scale(ref_coef(set_idx, KCRR), COEF_FRAC));
    k_crg   = CW'(coef_scale(ref_coef(set_idx, KCRG), COEF_FRAC));
    k_cbg   = CW'(coef_scale(ref_coef(set_idx, KCBG), COEF_FRAC));
    k_cbb   = CW'(coef_scale(ref_coef(set_idx, KCBB), COEF_FRAC));
  end

  // S3 combinational: sum, round, arithmetic shift
  logic signed [SW-1:0] r_rnd, g_rnd, b_rnd;

  always_comb begin
    r_rnd = (SW'(s2_py_q) + SW'(s2_pcrr_q) + ROUND_C) >>> COEF_FRAC;
    g_rnd = (SW'(s2_py_q) + SW'(s2_pcrg_q) + SW'(s2_pcbg_q) + ROUND_C) >>> COEF_FRAC;
    b_rnd = (SW'(s2_py_q) + SW'(s2_pcbb_q) + ROUND_C) >>> COEF_FRAC;
  end

  // S4 combinational: saturation
  logic [DATA_W-1:0] r_sat, g_sat, b_sat;
  logic              r_clip, g_clip, b_clip;

  ycc_rgb_clamp #(.IN_W(SW), .DATA_W(DATA_W)) u_clamp_r (
    .sum     (s3_r_q),
    .sat     (r_sat),
    .clipped (r_clip)
  );

  ycc_rgb_clamp #(.IN_W(SW), .DATA_W(DATA_W)) u_clamp_g (
    .sum     (s3_g_q),
    .sat     (g_sat),
    .clipped (g_clip)
  );

  ycc_rgb_clamp #(.IN_W(SW), .DATA_W(DATA_W)) u_clamp_b (
    .sum     (s3_b_q),
    .sat     (b_sat),
    .clipped (b_clip)
  );

  // Valids and output registers: reset, then advance as one when not stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      out_valid  <= 1'b0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      out_user   <= '0;
      out_clip_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      out_valid  <= s3_valid_q;
      if (s3_valid_q) begin
        red        <= r_sat;
        green      <= g_sat;
        blue       <= b_sat;
        out_user   <= s3_user_q;
        out_clip_q <= r_clip | g_clip | b_clip;
      end
    end
  end

  // Datapath registers need no reset; their valids qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_y_q    <= y_off;
      s1_cb_q   <= cb_off;
      s1_cr_q   <= cr_off;
      s1_side_q <= in_side;
      s1_user_q <= in_user;

      s2_py_q   <= PW'(s1_y_q)  * PW'(k_y);
      s2_pcrr_q <= PW'(s1_cr_q) * PW'(k_crr);
      s2_pcrg_q <= PW'(s1_cr_q) * PW'(k_crg);
      s2_pcbg_q <= PW'(s1_cb_q) * PW'(k_cbg);
      s2_pcbb_q <= PW'(s1_cb_q) * PW'(k_cbb);
      s2_user_q <= s1_user_q;

      s3_r_q    <= r_rnd;
      s3_g_q    <= g_rnd;
      s3_b_q    <= b_rnd;
      s3_user_q <= s2_user_q;
    end
  end

  // Saturating clip statistic; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      clip_count <= '0;
    end else if (out_valid && out_ready && out_clip_q && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ycbcr_to_rgb_pipe.sv
// Directed bench for ycbcr_to_rgb_pipe at DATA_W=8, COEF_FRAC=7, full-range build.
module tb_ycbcr_to_rgb_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] y, cb, cr;
  logic [1:0] in_user;
  logic       in_valid, in_ready, matrix_sel;
  logic [7:0] red, green, blue;
  logic [1:0] out_user;
  logic       out_valid, out_ready, clr_stats;
  logic [15:0] clip_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ycbcr_to_rgb_pipe #(.DATA_W(8), .COEF_FRAC(7), .USER_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .y          (y),
    .cb         (cb),
    .cr         (cr),
    .in_user    (in_user),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .matrix_sel (matrix_sel),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .out_user   (out_user),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .clr_stats  (clr_stats),
    .clip_count (clip_count)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one pixel into an idle pipeline, then check latency and the RGB result.
  task automatic run_pix(input string tag, input int yv, input int cbv, input int crv,
                         input logic sel, input int er, input int eg, input int eb);
    int lat;
    y = 8'(yv); cb = 8'(cbv); cr = 8'(crv); matrix_sel = sel; in_user = 2'd1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, lat, 4);
    check({tag, ".r"}, int'(red), er);
    check({tag, ".g"}, int'(green), eg);
    check({tag, ".b"}, int'(blue), eb);
    step();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int got, sent, leaks;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
    y = '0; cb = '0; cr = '0; in_user = '0; matrix_sel = 1'b0;
    step();
    step();
    check("reset.out_valid", int'(out_valid), 0);
    check("reset.clip_count", int'(clip_count), 0);
    check("reset.red", int'(red), 0);
    check("reset.out_user", int'(out_user), 0);
    rst = 1'b0;
    step();
    check("reset.in_ready", int'(in_ready), 1);
    out_ready = 1'b1;

    run_pix("grey601", 128, 128, 128, 1'b0, 128, 128, 128);
    check("grey601.clip", int'(clip_count), 0);
    run_pix("red601", 100, 128, 200, 1'b0, 201, 49, 100);
    run_pix("mix601", 150, 100, 180, 1'b0, 223, 123, 100);
    run_pix("mix709", 150, 100, 180, 1'b1, 232, 131, 98);
    check("nonclip.clip", int'(clip_count), 0);
    run_pix("sat_hi", 255, 128, 255, 1'b0, 255, 165, 255);
    check("sat_hi.clip", int'(clip_count), 1);
    run_pix("sat_lo", 0, 0, 128, 1'b0, 0, 44, 0);
    check("sat_lo.clip", int'(clip_count), 2);

    // Stream of 10 grey pixels, out_ready low for cycles 3..8.
    got = 0; sent = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 3 && c <= 8);
      if (sent < 10) begin
        in_valid = 1'b1; y = 8'(20 + 10 * sent); cb = 8'd128; cr = 8'd128;
        in_user = 2'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        check("stall.in_ready", int'(in_ready), 0);
        check("stall.r_hold", int'(red), 20 + 10 * got);
        check("stall.user_hold", int'(out_user), got % 4);
      end
      if (out_valid && out_ready) begin
        check("stream.r", int'(red), 20 + 10 * got);
        check("stream.g", int'(green), 20 + 10 * got);
        check("stream.user", int'(out_user), got % 4);
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream.count", got, 10);
    check("stream.clip", int'(clip_count), 2);

    // Mid-flight reset: three clipping pixels in S1..S3 are discarded.
    y = 8'd255; cb = 8'd128; cr = 8'd255; in_valid = 1'b1;
    step();
    step();
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    check("flush.out_valid", int'(out_valid), 0);
    check("flush.clip_count", int'(clip_count), 0);
    rst = 1'b0;
    leaks = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) leaks++;
      step();
    end
    check("flush.leaks", leaks, 0);
    check("flush.clip_after", int'(clip_count), 0);

    // Drive the statistic into saturation with back-to-back clipped pixels.
    y = 8'd255; cb = 8'd128; cr = 8'd255; in_valid = 1'b1;
    for (int c = 0; c < 65545; c++) step();
    check("sat.ffff", int'(clip_count), 32'hFFFF);
    step();
    step();
    step();
    check("sat.hold", int'(clip_count), 32'hFFFF);
    check("sat.pre_valid", int'(out_valid), 1);
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    check("sat.clr", int'(clip_count), 0);
    step();
    check("sat.recount", int'(clip_count), 1);
    in_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
